// File: rtl/mbc_banker.sv
// Game Boy cartridge bank controller for none/MBC1/MBC1M/MBC2/MBC5 carts with savestate access.
// Optional feature macro: MBC_RUMBLE_EN (MBC5 rumble carts drive the motor from ram_bank[3]).
module mbc_banker #(
  parameter int ROM_BANK_W = 9,
  parameter int RAM_BANK_W = 4
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  ce_cpu,
  input  logic [2:0]            mode,
  input  logic [ROM_BANK_W-1:0] rom_mask,
  input  logic [RAM_BANK_W-1:0] ram_mask,
  input  logic                  has_ram,
  input  logic                  rumble_cart,
  input  logic [15:0]           cart_addr,
  input  logic                  cart_wr,
  input  logic [7:0]            cart_di,
  input  logic [7:0]            cram_di,
  output logic [7:0]            cram_do,
  output logic [RAM_BANK_W+12:0] cram_addr,
  output logic [ROM_BANK_W-1:0] rom_bank,
  output logic                  ram_enabled,
  output logic                  rumble,
  input  logic                  ss_load,
  input  logic [31:0]           ss_data,
  output logic [31:0]           ss_back
);

  typedef enum logic [2:0] {
    MODE_NONE  = 3'd0,
    MODE_MBC1  = 3'd1,
    MODE_MBC1M = 3'd2,
    MODE_MBC2  = 3'd3,
    MODE_MBC5  = 3'd4
  } mode_e;

  localparam int ROM_RAW_W = (ROM_BANK_W > 9) ? ROM_BANK_W : 9;
  localparam int RAM_RAW_W = (RAM_BANK_W > 4) ? RAM_BANK_W : 4;

  logic [7:0] rom_lo;
  logic       rom_hi;
  logic [3:0] ram_bank;
  logic       bmode;
  logic       ram_en;
  logic [2:0] mode_q;

  logic is_mbc1, is_mbc1m, is_mbc2, is_mbc5, is_none, is_mbc1_any;
  logic wr_en, high_area;
  logic [ROM_RAW_W-1:0]  rom_raw;
  logic [3:0]            bank_src;
  logic                  rumble_int;
  logic [RAM_RAW_W-1:0]  bank_ext;
  logic [RAM_BANK_W-1:0] ram_bank_eff;
  logic                  unused_bits;

  assign is_mbc1     = (mode == MODE_MBC1);
  assign is_mbc1m    = (mode == MODE_MBC1M);
  assign is_mbc2     = (mode == MODE_MBC2);
  assign is_mbc5     = (mode == MODE_MBC5);
  assign is_none     = !(is_mbc1 || is_mbc1m || is_mbc2 || is_mbc5);
  assign is_mbc1_any = is_mbc1 || is_mbc1m;
  assign wr_en       = cart_wr && ce_cpu && !cart_addr[15];
  assign high_area   = cart_addr[14];
  assign unused_bits = &{1'b0, ss_data[31:15], rumble_cart};

  // Savestate load beats a mode change, which in turn swallows any same-cycle write.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_lo   <= 8'd1;
      rom_hi   <= 1'b0;
      ram_bank <= 4'd0;
      bmode    <= 1'b0;
      ram_en   <= 1'b0;
      mode_q   <= 3'd0;
    end else begin
      mode_q <= mode;
      if (ss_load) begin
        rom_lo   <= ss_data[7:0];
        rom_hi   <= ss_data[8];
        ram_bank <= ss_data[12:9];
        bmode    <= ss_data[13];
        ram_en   <= ss_data[14];
      end else if (mode != mode_q) begin
        rom_lo   <= 8'd1;
        rom_hi   <= 1'b0;
        ram_bank <= 4'd0;
        bmode    <= 1'b0;
        ram_en   <= 1'b0;
      end else if (wr_en) begin
        case (cart_addr[14:13])
          2'b00: if (!is_mbc2 || !cart_addr[8]) ram_en <= (cart_di[3:0] == 4'hA);
          2'b01: begin
            if (is_mbc1)
              rom_lo[4:0] <= (cart_di[4:0] == 5'd0) ? 5'd1 : cart_di[4:0];
            else if (is_mbc1m)
              rom_lo[4:0] <= (cart_di[4:0] == 5'd0) ? 5'd1 : {1'b0, cart_di[3:0]};
            else if (is_mbc2 && cart_addr[8])
              rom_lo[3:0] <= (cart_di[3:0] == 4'd0) ? 4'd1 : cart_di[3:0];
            else if (is_mbc5) begin
              if (cart_addr[12]) rom_hi <= cart_di[0];
              else               rom_lo <= cart_di;
            end
          end
          2'b10: ram_bank <= is_mbc1_any ? {2'b00, cart_di[1:0]} : cart_di[3:0];
          default: if (is_mbc1_any) bmode <= cart_di[0];
        endcase
      end
    end
  end

  always_comb begin
    rom_raw = '0;
    if (is_mbc1)
      rom_raw = high_area ? ROM_RAW_W'({ram_bank[1:0], rom_lo[4:0]})
                          : (bmode ? ROM_RAW_W'({ram_bank[1:0], 5'd0}) : '0);
    else if (is_mbc1m)
      rom_raw = high_area ? ROM_RAW_W'({ram_bank[1:0], rom_lo[3:0]})
                          : (bmode ? ROM_RAW_W'({ram_bank[1:0], 4'd0}) : '0);
    else if (is_mbc2)
      rom_raw = high_area ? ROM_RAW_W'(rom_lo[3:0]) : '0;
    else if (is_mbc5)
      rom_raw = high_area ? ROM_RAW_W'({rom_hi, rom_lo}) : '0;
    else
      rom_raw = ROM_RAW_W'(high_area);
  end

  assign rom_bank = rom_raw[ROM_BANK_W-1:0] & rom_mask;

  // On rumble carts bit 3 of the RAM bank drives the motor instead of addressing RAM.
  always_comb begin
    bank_src   = ram_bank;
    rumble_int = 1'b0;
`ifdef MBC_RUMBLE_EN
    if (is_mbc5 && rumble_cart) begin
      rumble_int  = ram_bank[3];
      bank_src[3] = 1'b0;
    end
`endif
    if (is_none || is_mbc2 || (is_mbc1 && !bmode)) bank_src = 4'd0;
  end

  assign bank_ext     = RAM_RAW_W'(bank_src);
  assign ram_bank_eff = bank_ext[RAM_BANK_W-1:0] & ram_mask;
  assign rumble       = rumble_int;

  assign cram_addr = is_mbc2 ? {{(RAM_BANK_W+4){1'b0}}, cart_addr[8:0]}
                             : {ram_bank_eff, cart_addr[12:0]};

  assign ram_enabled = is_none ? has_ram : (is_mbc2 ? ram_en : (ram_en && has_ram));

  assign cram_do = !ram_enabled ? 8'hFF : (is_mbc2 ? {4'hF, cram_di[3:0]} : cram_di);

  assign ss_back = {17'd0, ram_en, bmode, ram_bank, rom_hi, rom_lo};

endmodule

// File: tb/tb_mbc_banker.sv
// Bench for mbc_banker: constant vector table, hand-written corner sequences and
// randomized traffic checked against an arithmetic model of the bank controller.
module tb_mbc_banker;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ce_cpu;
  logic [2:0]  mode;
  logic [8:0]  rom_mask;
  logic [3:0]  ram_mask;
  logic        has_ram;
  logic        rumble_cart;
  logic [15:0] cart_addr;
  logic        cart_wr;
  logic [7:0]  cart_di;
  logic [7:0]  cram_di;
  logic [7:0]  cram_do;
  logic [16:0] cram_addr;
  logic [8:0]  rom_bank;
  logic        ram_enabled;
  logic        rumble;
  logic        ss_load;
  logic [31:0] ss_data;
  logic [31:0] ss_back;

  int checks = 0;
  int errors = 0;

  // model state
  int m_rom_lo, m_rom_hi, m_ram_bank, m_bmode, m_ram_en, m_mode_q;

  mbc_banker #(.ROM_BANK_W(9), .RAM_BANK_W(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_cpu(ce_cpu), .mode(mode),
    .rom_mask(rom_mask), .ram_mask(ram_mask), .has_ram(has_ram),
    .rumble_cart(rumble_cart), .cart_addr(cart_addr), .cart_wr(cart_wr),
    .cart_di(cart_di), .cram_di(cram_di), .cram_do(cram_do),
    .cram_addr(cram_addr), .rom_bank(rom_bank), .ram_enabled(ram_enabled),
    .rumble(rumble), .ss_load(ss_load), .ss_data(ss_data), .ss_back(ss_back)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [2:0]  vmode;
    logic [15:0] waddr;
    logic [7:0]  wdata;
    logic [15:0] raddr;
    logic [8:0]  exp_rom;
    logic [31:0] exp_ss;
  } vec_t;

  vec_t vecs[16];

  function automatic int md();
    return (mode > 3'd4) ? 0 : int'(mode);
  endfunction

  function automatic void model_reset_regs();
    m_rom_lo = 1; m_rom_hi = 0; m_ram_bank = 0; m_bmode = 0; m_ram_en = 0;
  endfunction

  function automatic void model_write(int a, int d);
    int v;
    int m = md();
    if (a < 'h2000) begin
      if (m != 3 || (a & 'h100) == 0) m_ram_en = ((d % 16) == 10) ? 1 : 0;
    end else if (a < 'h4000) begin
      if (m == 1) begin
        v = d % 32; if (v == 0) v = 1;
        m_rom_lo = (m_rom_lo & 'hE0) + v;
      end else if (m == 2) begin
        v = ((d % 32) == 0) ? 1 : d % 16;
        m_rom_lo = (m_rom_lo & 'hE0) + v;
      end else if (m == 3 && (a & 'h100) != 0) begin
        v = d % 16; if (v == 0) v = 1;
        m_rom_lo = (m_rom_lo & 'hF0) + v;
      end else if (m == 4) begin
        if (a < 'h3000) m_rom_lo = d; else m_rom_hi = d % 2;
      end
    end else if (a < 'h6000) begin
      m_ram_bank = (m == 1 || m == 2) ? d % 4 : d % 16;
    end else if (m == 1 || m == 2) begin
      m_bmode = d % 2;
    end
  endfunction

  // Applies the register-update rules at a rising edge using the inputs present then.
  function automatic void model_clock();
    int sd = int'(ss_data & 32'h7FFF);
    if (ss_load) begin
      m_rom_lo = sd % 256; m_rom_hi = (sd / 256) % 2; m_ram_bank = (sd / 512) % 16;
      m_bmode = (sd / 8192) % 2; m_ram_en = (sd / 16384) % 2;
    end else if (int'(mode) != m_mode_q) begin
      model_reset_regs();
    end else if (cart_wr && ce_cpu && cart_addr < 16'h8000) begin
      model_write(int'(cart_addr), int'(cart_di));
    end
    m_mode_q = int'(mode);
  endfunction

  function automatic int model_rom();
    int r = 0;
    int a = int'(cart_addr);
    int hi = (a / 16384) % 2;
    case (md())
      1: r = hi ? (m_ram_bank % 4) * 32 + m_rom_lo % 32 : (m_bmode ? (m_ram_bank % 4) * 32 : 0);
      2: r = hi ? (m_ram_bank % 4) * 16 + m_rom_lo % 16 : (m_bmode ? (m_ram_bank % 4) * 16 : 0);
      3: r = hi ? m_rom_lo % 16 : 0;
      4: r = hi ? m_rom_hi * 256 + m_rom_lo : 0;
      default: r = hi;
    endcase
    return r & int'(rom_mask);
  endfunction

  function automatic int model_rumble();
`ifdef MBC_RUMBLE_EN
    if (md() == 4 && rumble_cart) return (m_ram_bank / 8) % 2;
`endif
    return 0;
  endfunction

  function automatic int model_cram_addr();
    int a = int'(cart_addr);
    int b = m_ram_bank;
    if (md() == 3) return a % 512;
`ifdef MBC_RUMBLE_EN
    if (md() == 4 && rumble_cart) b = b % 8;
`endif
    if (md() == 0 || (md() == 1 && m_bmode == 0)) b = 0;
    b = b & int'(ram_mask);
    return b * 8192 + a % 8192;
  endfunction

  function automatic int model_ram_enabled();
    if (md() == 0) return int'(has_ram);
    if (md() == 3) return m_ram_en;
    return m_ram_en & int'(has_ram);
  endfunction

  function automatic int model_cram_do();
    if (model_ram_enabled() == 0) return 'hFF;
    if (md() == 3) return 'hF0 + int'(cram_di) % 16;
    return int'(cram_di);
  endfunction

  function automatic int model_ss();
    return m_ram_en * 16384 + m_bmode * 8192 + m_ram_bank * 512 + m_rom_hi * 256 + m_rom_lo;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check_val({tag, " rom_bank"},    32'(rom_bank),    32'(model_rom()));
    check_val({tag, " cram_addr"},   32'(cram_addr),   32'(model_cram_addr()));
    check_val({tag, " ram_enabled"}, 32'(ram_enabled), 32'(model_ram_enabled()));
    check_val({tag, " cram_do"},     32'(cram_do),     32'(model_cram_do()));
    check_val({tag, " rumble"},      32'(rumble),      32'(model_rumble()));
    check_val({tag, " ss_back"},     ss_back,          32'(model_ss()));
  endtask

  task automatic idle_cycle();
    @(posedge clk_sys); model_clock(); #1;
  endtask

  task automatic apply_stimulus(input logic [15:0] a, input logic [7:0] d, input logic ce = 1'b1);
    cart_addr = a; cart_di = d; cart_wr = 1'b1; ce_cpu = ce;
    @(posedge clk_sys); model_clock(); #1;
    cart_wr = 1'b0; ce_cpu = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{3'd1, 16'h2000, 8'h00, 16'h4000, 9'h001, 32'h0001};
    vecs[1]  = '{3'd1, 16'h4000, 8'h02, 16'h4000, 9'h041, 32'h0401};
    vecs[2]  = '{3'd1, 16'h6000, 8'h01, 16'h0000, 9'h040, 32'h2401};
    vecs[3]  = '{3'd1, 16'h2000, 8'h1F, 16'h4000, 9'h05F, 32'h241F};
    vecs[4]  = '{3'd1, 16'h2000, 8'h20, 16'h4000, 9'h041, 32'h2401};
    vecs[5]  = '{3'd4, 16'h2000, 8'h33, 16'h4000, 9'h001, 32'h0001};
    vecs[6]  = '{3'd4, 16'h2000, 8'h00, 16'h4000, 9'h000, 32'h0000};
    vecs[7]  = '{3'd4, 16'h3000, 8'h01, 16'h4000, 9'h100, 32'h0100};
    vecs[8]  = '{3'd4, 16'h2000, 8'h20, 16'h4000, 9'h120, 32'h0120};
    vecs[9]  = '{3'd4, 16'h3000, 8'hFE, 16'h4000, 9'h020, 32'h0020};
    vecs[10] = '{3'd1, 16'h2000, 8'h05, 16'h4000, 9'h001, 32'h0001};
    vecs[11] = '{3'd2, 16'h2000, 8'h10, 16'h4000, 9'h001, 32'h0001};
    vecs[12] = '{3'd2, 16'h2000, 8'h10, 16'h4000, 9'h000, 32'h0000};
    vecs[13] = '{3'd2, 16'h4000, 8'h03, 16'h4000, 9'h030, 32'h0600};
    vecs[14] = '{3'd2, 16'h6000, 8'h01, 16'h0000, 9'h030, 32'h2600};
    vecs[15] = '{3'd2, 16'h2000, 8'h0F, 16'h4000, 9'h03F, 32'h260F};

    reset_n = 1'b0; ce_cpu = 1'b1; mode = 3'd1; rom_mask = 9'h1FF; ram_mask = 4'hF;
    has_ram = 1'b1; rumble_cart = 1'b0; cart_addr = 16'h4000; cart_wr = 1'b0;
    cart_di = 8'h00; cram_di = 8'h5A; ss_load = 1'b0; ss_data = 32'h0;
    model_reset_regs(); m_mode_q = 0;

    #12;
    check_val("reset ss_back", ss_back, 32'h1);
    check_val("reset rom_bank", 32'(rom_bank), 32'h1);
    check_val("reset ram_enabled", 32'(ram_enabled), 32'h0);
    check_val("reset cram_do", 32'(cram_do), 32'hFF);
    check_val("reset rumble", 32'(rumble), 32'h0);
    @(negedge clk_sys); reset_n = 1'b1;
    idle_cycle();

    for (int i = 0; i < 16; i++) begin
      mode = vecs[i].vmode;
      apply_stimulus(vecs[i].waddr, vecs[i].wdata);
      cart_addr = vecs[i].raddr; #1;
      check_val($sformatf("vec%0d rom_bank", i), 32'(rom_bank), 32'(vecs[i].exp_rom));
      check_val($sformatf("vec%0d ss_back", i), ss_back, vecs[i].exp_ss);
    end

    // MBC5 ninth bank bit and ROM masking
    mode = 3'd4; idle_cycle();
    apply_stimulus(16'h3000, 8'h01);
    apply_stimulus(16'h2000, 8'h00);
    cart_addr = 16'h4000; #1;
    check_val("mbc5 bank 0x100", 32'(rom_bank), 32'h100);
    rom_mask = 9'h0FF; #1;
    check_val("mbc5 masked", 32'(rom_bank), 32'h000);
    rom_mask = 9'h1FF;

    // MBC2 address-bit-8 qualification, nibble RAM, ce gating
    mode = 3'd3; idle_cycle();
    apply_stimulus(16'h0100, 8'h0A); #1;
    check_val("mbc2 a8 ram_en", 32'(ram_enabled), 32'h0);
    check_val("mbc2 a8 ss_back", ss_back, 32'h1);
    apply_stimulus(16'h0000, 8'h0A);
    cart_addr = 16'hA3C5; cram_di = 8'h35; has_ram = 1'b0; #1;
    check_val("mbc2 ram_enabled", 32'(ram_enabled), 32'h1);
    check_val("mbc2 cram_do", 32'(cram_do), 32'hF5);
    check_val("mbc2 cram_addr", 32'(cram_addr), 32'h1C5);
    has_ram = 1'b1;
    apply_stimulus(16'h2100, 8'h07, 1'b0);
    cart_addr = 16'h4000; #1;
    check_val("ce gated write", 32'(rom_bank), 32'h1);
    apply_stimulus(16'h2100, 8'h07, 1'b1);
    cart_addr = 16'h4000; #1;
    check_val("ce write", 32'(rom_bank), 32'h7);

    // savestate load beats a write and a mode change
    mode = 3'd1; idle_cycle();
    ss_data = 32'h0000_6A05; ss_load = 1'b1;
    cart_addr = 16'h2000; cart_di = 8'h1F; cart_wr = 1'b1;
    @(posedge clk_sys); model_clock(); #1;
    ss_load = 1'b0; cart_wr = 1'b0; cart_addr = 16'h4000; #1;
    check_val("ss load ss_back", ss_back, 32'h6A05);
    check_val("ss load rom_bank", 32'(rom_bank), 32'h25);
    mode = 3'd4; ss_data = 32'h0000_0123; ss_load = 1'b1;
    @(posedge clk_sys); model_clock(); #1;
    ss_load = 1'b0; #1;
    check_val("ss over mode ss_back", ss_back, 32'h123);
    check_val("ss over mode rom_bank", 32'(rom_bank), 32'h123);

    // rumble variant
    rumble_cart = 1'b1;
    apply_stimulus(16'h0000, 8'h0A);
    apply_stimulus(16'h4000, 8'h0B);
    cart_addr = 16'hA000; #1;
`ifdef MBC_RUMBLE_EN
    check_val("rumble on", 32'(rumble), 32'h1);
    check_val("rumble cram_addr", 32'(cram_addr), 32'h6000);
`else
    check_val("rumble off", 32'(rumble), 32'h0);
    check_val("rumble cram_addr", 32'(cram_addr), 32'h16000);
`endif
    check_val("rumble ram_enabled", 32'(ram_enabled), 32'h1);
    check_val("rumble ss_back", ss_back, 32'h5723);

    // asynchronous reset mid-run
    cart_addr = 16'h4000; #2;
    reset_n = 1'b0; #1;
    check_val("async reset ss_back", ss_back, 32'h1);
    check_val("async reset rumble", 32'(rumble), 32'h0);
    check_val("async reset ram_enabled", 32'(ram_enabled), 32'h0);
    check_val("async reset cram_do", 32'(cram_do), 32'hFF);
    check_val("async reset rom_bank", 32'(rom_bank), 32'h1);
    model_reset_regs(); m_mode_q = 0;
    @(negedge clk_sys); reset_n = 1'b1;
    idle_cycle();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) mode = 3'($urandom_range(0, 7));
      cart_addr   = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 16'h7FFF)) : 16'($urandom);
      cart_di     = 8'($urandom);
      cart_wr     = 1'($urandom);
      ce_cpu      = 1'($urandom);
      ss_load     = ($urandom_range(0, 31) == 0);
      ss_data     = $urandom;
      rom_mask    = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'h1FF;
      ram_mask    = 4'($urandom);
      has_ram     = 1'($urandom);
      rumble_cart = 1'($urandom);
      cram_di     = 8'($urandom);
      #2;
      check_output($sformatf("rand%0d", n));
      @(posedge clk_sys); model_clock(); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mbc_banker.md
# mbc_banker

Parametrised, mode-selectable Game Boy cartridge bank controller: one register file and address generator covering no-mapper, MBC1, MBC1M, MBC2 and MBC5 carts. ROM and RAM bank widths are generics, so one instance serves every supported cart size. It sits between the CPU cartridge bus and the SDRAM/BRAM address path. It also provides single-cycle savestate load and readback of its bank state.

## Interface
Parameters:
- ROM_BANK_W, 9, width of the 16 KB ROM bank number.
- RAM_BANK_W, 4, width of the 8 KB RAM bank number.

Ports:
- clk_sys  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ce_cpu  in  1  CPU clock enable; qualifies cart_wr.
- mode  in  3  0 none, 1 MBC1, 2 MBC1M, 3 MBC2, 4 MBC5; 5-7 behave as none.
- rom_mask  in  ROM_BANK_W  ANDed onto the output ROM bank.
- ram_mask  in  RAM_BANK_W  ANDed onto the output RAM bank.
- has_ram  in  1  cart carries external RAM.
- rumble_cart  in  1  MBC5 rumble variant.
- cart_addr  in  16  CPU address.
- cart_wr  in  1  CPU write strobe.
- cart_di  in  8  CPU write data.
- cram_di  in  8  cart RAM read data.
- cram_do  out  8  RAM data returned to the CPU.
- cram_addr  out  RAM_BANK_W+13  cart RAM byte address.
- rom_bank  out  ROM_BANK_W  16 KB bank for the current cart_addr.
- ram_enabled  out  1  RAM access permitted.
- rumble  out  1  rumble motor drive.
- ss_load  in  1  load state from ss_data.
- ss_data  in  32  savestate input word.
- ss_back  out  32  savestate output word.

## Operation
Registers and their reset values:
- rom_lo[7:0] = 1
- rom_hi = 0
- ram_bank[3:0] = 0
- bmode = 0
- ram_en = 0
- mode_q = mode sampled each cycle

Register writes (cart_wr & ce_cpu, cart_addr[15] = 0):
- 0x0000-0x1FFF: ram_en = (cart_di[3:0] == 0xA). In MBC2 only when cart_addr[8] = 0.
- 0x2000-0x3FFF:
  - MBC1: rom_lo[4:0] = cart_di[4:0]; a zero value becomes 1.
  - MBC1M: rom_lo[4:0] = {0, cart_di[3:0]}; zero is checked on [4:0] before truncation and becomes 1.
  - MBC2, only when cart_addr[8] = 1: rom_lo[3:0] = cart_di[3:0]; zero becomes 1.
  - MBC5, 0x2000-0x2FFF: rom_lo = cart_di, and zero is allowed.
  - MBC5, 0x3000-0x3FFF: rom_hi = cart_di[0].
- 0x4000-0x5FFF: ram_bank = cart_di[3:0]. MBC1 and MBC1M use only [1:0]; the upper bits are written as 0.
- 0x6000-0x7FFF: MBC1 and MBC1M only, bmode = cart_di[0].

ROM bank (combinational, then ANDed with rom_mask, zero-extended or truncated to ROM_BANK_W):
- none: cart_addr[14].
- MBC1, low area: bmode ? ram_bank[1:0]<<5 : 0. High area: {ram_bank[1:0], rom_lo[4:0]}.
- MBC1M: as MBC1 but with shift 4 and rom_lo[3:0].
- MBC2: low area 0, high area rom_lo[3:0].
- MBC5: low area 0, high area {rom_hi, rom_lo}.

RAM path:
- Effective bank: ram_bank & ram_mask. It is forced to 0 for none, MBC2, and MBC1 with bmode = 0.
- cram_addr = {bank, cart_addr[12:0]}. For MBC2: {0, cart_addr[8:0]}.
- ram_enabled = ram_en & has_ram. MBC2 ignores has_ram. none mode: has_ram.
- cram_do:
  - 0xFF when !ram_enabled.
  - {4'hF, cram_di[3:0]} in MBC2.
  - cram_di otherwise.

Mode change:
- mode != mode_q restores all bank registers to reset values on that edge.
- cart_wr in the same cycle is ignored.

Savestate packing: ss_back = {17'b0, ram_en, bmode, ram_bank, rom_hi, rom_lo}.
- ss_load loads the same fields on the edge, regardless of ce_cpu.
- ss_load has priority over cart_wr and over a mode change.

## Timing
- Register writes take effect on the qualifying edge. rom_bank, cram_addr and ram_enabled reflect them from the next cycle; the address paths are combinational from registers.
- All outputs follow the reset register values asynchronously while reset_n = 0:
  - rom_bank = mode-dependent with rom_lo = 1.
  - ram_enabled = 0 (except none/MBC2 rules).
  - cram_do = 0xFF when disabled.
  - rumble = 0.
  - ss_back = 0x00000001.
- Asserting reset mid-sequence discards all pending bank state; no write is partially applied.
- Writes with ce_cpu = 0 are ignored, so the same strobe held across cycles applies once per ce pulse.

## Configuration
- MBC_RUMBLE_EN defined: in MBC5 with rumble_cart = 1, rumble = ram_bank[3], and ram_bank[3] is forced 0 in cram_addr.
- MBC_RUMBLE_EN undefined: rumble is tied 0 and ram_bank[3] is always an address bit.

## Test plan
- MBC1, write 0x00 to 0x2000, read at 0x4000 -> rom_bank = 1. Write 0x02 to 0x4000 and 0x01 to 0x6000 -> rom_bank = 0x40 at 0x0000 and 0x41 at 0x4000.
- MBC5, 0x2000 <- 0x00, 0x3000 <- 0x01, rom_mask = 0x1FF -> rom_bank = 0x100. With rom_mask = 0x0FF -> rom_bank = 0x00.
- MBC2, write 0x0A to 0x0100 -> ram_en stays 0. Write 0x0A to 0x0000 -> ram_enabled = 1. cram_di = 0x35 -> cram_do = 0xF5, cram_addr = cart_addr[8:0].
- ss_load with ss_data = 0x00006A05 while cart_wr targets 0x2000 -> ss_back = 0x00006A05 next cycle, and the write is dropped.
- MBC5 with rumble_cart = 1 and MBC_RUMBLE_EN defined: 0x4000 <- 0x0B -> rumble = 1, cram_addr bank = 3. Without the macro -> rumble = 0, bank = 0xB & ram_mask.
- Switch mode from 4 to 1 with rom_lo = 0x20 -> next cycle rom_lo = 1 and rom_bank at 0x4000 = 1. Pulse reset_n low mid-run -> ss_back = 0x00000001 immediately.
